// File: rtl/result_fifo.sv
// Result buffer behind the affine compute stage: a circular FIFO with valid/ready readout and a sticky drop flag.
// Optional high-water-mark output enabled by defining RESULT_FIFO_PEAK_EN.
module result_fifo #(
   parameter  int W     = 16,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic signed [W-1:0] X,
   input  logic                out_ready,
   output logic                out_valid,
   output logic signed [W-1:0] Y,
   output logic [AW:0]         count,
   output logic                overflow
`ifdef RESULT_FIFO_PEAK_EN
   ,
   output logic [AW:0]         peak
`endif
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count_nxt;
   logic          push, pop, drop;

   // The upstream cannot stall, so a full FIFO only accepts a word when the head leaves in the same cycle.
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   assign push      = in_valid && ((count != FULL) || pop);
   assign drop      = in_valid && (count == FULL) && !pop;
   assign Y         = out_valid ? mem[rd_ptr] : '0;

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + 1'b1;
      else if (pop && !push)
         count_nxt = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (drop) overflow <= 1'b1;
         count <= count_nxt;
      end
   end

   // Storage is deliberately left uncleared on reset; Y is masked while empty instead.
   always_ff @(posedge clk) begin
      if (!rst && push)
         mem[wr_ptr] <= X;
   end

`ifdef RESULT_FIFO_PEAK_EN
   always_ff @(posedge clk) begin
      if (rst)
         peak <= '0;
      else if (count_nxt > peak)
         peak <= count_nxt;
   end
`endif

endmodule

// File: tb/tb_result_fifo.sv
// Directed self-checking bench for result_fifo (DEPTH=8, W=16); peak is checked too when RESULT_FIFO_PEAK_EN is defined.
module tb_result_fifo;

   localparam int W     = 16;
   localparam int DEPTH = 8;
   localparam int AW    = $clog2(DEPTH);

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic signed [W-1:0] X;
   logic                out_ready;
   logic                out_valid;
   logic signed [W-1:0] Y;
   logic [AW:0]         count;
   logic                overflow;
`ifdef RESULT_FIFO_PEAK_EN
   logic [AW:0]         peak;
`endif

   int tests  = 0;
   int failed = 0;

   result_fifo #(.W(W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .X         (X),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .Y         (Y),
      .count     (count),
      .overflow  (overflow)
`ifdef RESULT_FIFO_PEAK_EN
      ,
      .peak      (peak)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b1; X = 16'sd123; out_ready = 1'b0;

      // reset dominates a pushing upstream
      tick(); tick();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_Y", Y, 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_overflow", 32'(overflow), 0);
`ifdef RESULT_FIFO_PEAK_EN
      chk("rst_peak", 32'(peak), 0);
`endif
      rst = 1'b0; in_valid = 1'b0;

      // ready while empty does nothing
      out_ready = 1'b1; tick();
      chk("empty_ready_count", 32'(count), 0);
      out_ready = 1'b0;

      // basic order
      in_valid = 1'b1;
      X = 16'sd5;     tick();
      chk("basic_first_visible", 32'(out_valid), 1);
      X = -16'sd3;    tick();
      X = 16'sd32767; tick();
      in_valid = 1'b0;
      chk("basic_count3", 32'(count), 3);
      chk("basic_Y0", Y, 5);
      out_ready = 1'b1;
      tick(); chk("basic_Y1", Y, -3);
      tick(); chk("basic_Y2", Y, 32767);
      tick();
      chk("basic_drained_valid", 32'(out_valid), 0);
      chk("basic_drained_count", 32'(count), 0);
      chk("basic_drained_Y", Y, 0);
      out_ready = 1'b0;

      // overflow: 9 words into 8 slots
      in_valid = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         X = W'(i); tick();
      end
      chk("ovf_count8", 32'(count), 8);
      chk("ovf_not_yet", 32'(overflow), 0);
`ifdef RESULT_FIFO_PEAK_EN
      chk("ovf_peak", 32'(peak), 8);
`endif
      X = 16'sd9; tick();
      in_valid = 1'b0;
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_count_held", 32'(count), 8);
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("ovf_drain_%0d", i), Y, i);
         tick();
      end
      chk("ovf_nine_absent", 32'(out_valid), 0);
      chk("ovf_sticky", 32'(overflow), 1);
      out_ready = 1'b0;

      // full with simultaneous pop accepts the word
      do_reset();
      chk("ovf_cleared_by_rst", 32'(overflow), 0);
      in_valid = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         X = W'(10 + i); tick();
      end
      X = 16'sd100; out_ready = 1'b1; tick();
      in_valid = 1'b0;
      chk("fullpop_count", 32'(count), 8);
      chk("fullpop_overflow", 32'(overflow), 0);
      for (int i = 2; i <= 8; i++) begin
         chk($sformatf("fullpop_drain_%0d", i), Y, 10 + i);
         tick();
      end
      chk("fullpop_last", Y, 100);
      tick();
      chk("fullpop_empty", 32'(out_valid), 0);
      out_ready = 1'b0;

      // streaming through the pointer wrap
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         X = W'(i); tick();
         chk($sformatf("stream_count_%0d", i), 32'(count), 1);
         chk($sformatf("stream_Y_%0d", i), Y, i);
      end
      in_valid = 1'b0; tick();
      chk("stream_end_count", 32'(count), 0);
      chk("stream_overflow", 32'(overflow), 0);
`ifdef RESULT_FIFO_PEAK_EN
      chk("stream_peak", 32'(peak), 1);
`endif
      out_ready = 1'b0;

      // reset mid-stream discards held words
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         X = W'(40 + i); tick();
      end
      chk("mid_count5", 32'(count), 5);
      rst = 1'b1; X = 16'sd55; tick();
      rst = 1'b0; in_valid = 1'b0;
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_valid", 32'(out_valid), 0);
      in_valid = 1'b1; X = 16'sd7; tick();
      in_valid = 1'b0;
      chk("mid_after_Y", Y, 7);
      chk("mid_after_count", 32'(count), 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/result_fifo.md
Name: result_fifo

Overview:
- Downstream buffer for the affine compute stage.
- Captures every result word presented with `in_valid` (that stage has no backpressure) into a DEPTH-entry circular FIFO.
- Re-presents the words in order on a valid/ready interface to the consumer (readout/serialiser).
- Flags any word lost because the FIFO was full.

Parameters:
- W, 16, data width; signed two's-complement, passed through unmodified.
- DEPTH, 8, number of storage entries; power of two, ≥2.
- AW, $clog2(DEPTH), pointer width; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word present this cycle.
- X  input  W (signed)  upstream result word.
- out_ready  input  1  consumer accepts the head word this cycle.
- out_valid  output  1  head word valid (FIFO not empty).
- Y  output  W (signed)  head word.
- count  output  AW+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: at least one word dropped since reset.
- peak  output  AW+1  only when RESULT_FIFO_PEAK_EN is defined (see Optional Feature).

Behaviour:
- Reset (rst=1 at posedge):
  - wr_ptr, rd_ptr, count and overflow go to 0; out_valid=0; Y=0.
  - Storage contents are not cleared.
  - Reset takes priority over any push or pop in the same cycle.
  - Reset mid-stream discards all held words.
- push = in_valid && (count<DEPTH || pop).
- pop = out_valid && out_ready.
- Push: mem[wr_ptr] <= X; wr_ptr increments, wrapping DEPTH-1→0.
- Pop: rd_ptr increments with the same wrap.
- count update:
  - push only: +1.
  - pop only: −1.
  - both or neither: unchanged.
- Full with simultaneous pop: the push is accepted; count stays DEPTH; no drop.
- Drop:
  - Condition: in_valid && count==DEPTH && !pop.
  - Word discarded; pointers and count unchanged; overflow <= 1.
  - overflow clears only on rst.
- out_valid = (count!=0), derived from registered count.
- Y = mem[rd_ptr] when count!=0, else 0. Y is never X/undefined when empty.
- Latency: a word pushed at edge N is visible on Y/out_valid after edge N, so it can pop at edge N+1. There is no same-cycle fall-through when empty.
- out_ready while empty: ignored; no pointer movement.
- Push and pop in the same cycle while count==1: the head pops, the new word becomes the head; count stays 1.
- Ordering: strict FIFO; no reordering or modification of data bits.
- No combinational path from in_valid/X to any output.
- Only out_ready feeds internal logic combinationally, via pop.

Optional Feature:
- Macro: RESULT_FIFO_PEAK_EN.
- Defined:
  - Adds output peak [AW:0], reset 0.
  - Each cycle peak <= max(peak, next count), so peak reaches DEPTH on the cycle the FIFO becomes full.
  - Cleared only by rst.
  - Used to size DEPTH on hardware.
- Undefined:
  - peak port and its register do not exist.
  - All other behaviour is identical.

Test Plan:
- Reset check: rst high 2 cycles with in_valid=1, X=123 → out_valid=0, Y=0, count=0, overflow=0 (peak=0 if enabled).
- Basic order: out_ready=0, push X=5,−3,32767 on 3 consecutive cycles → count=3; then out_ready=1 → Y sequence 5,−3,32767, out_valid drops after the third pop, count=0.
- Overflow: out_ready=0, push 9 words (1..9), DEPTH=8 → count=8, overflow=1 from the cycle after word 9; drain → 1..8; 9 absent; overflow stays 1.
- Full with simultaneous pop:
  - Setup: fill 8 words, then in_valid=1, X=100 with out_ready=1.
  - Response: head popped, 100 accepted, count=8, overflow=0; full drain ends with 100.
- Streaming/wrap: out_ready=1, in_valid=1 for 20 cycles, X=0..19 → count toggles 0/1 only, Y order 0..19, pointers wrap twice, overflow=0 (peak=1 if enabled).
- Mid-operation reset: 5 words held, assert rst 1 cycle with in_valid=1 → count=0, out_valid=0; next push X=7 appears as Y=7 with count=1.
